// File: rtl/mp_pkg.sv
// Shared definitions for the multi-precision adder datapath: FSM encoding,
// word-count and counter-width helpers, and the operand/word width check.
package mp_pkg;

  typedef enum logic [1:0] {
    s_LOAD_A = 2'b00,
    s_LOAD_B = 2'b01,
    s_START  = 2'b10,
    s_WAIT   = 2'b11
  } state_e;

  function automatic int unsigned n_words(input int unsigned op_w, input int unsigned word_w);
    return op_w / word_w;
  endfunction

  // One spare bit so a full count of n_words never wraps on its own.
  function automatic int unsigned cnt_width(input int unsigned nw);
    return $clog2(nw) + 1;
  endfunction

  function automatic int unsigned wd_width(input int unsigned timeout_cyc);
    return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
  endfunction

  function automatic bit widths_ok(input int unsigned op_w, input int unsigned word_w);
    return (word_w != 0) && (op_w >= word_w) && ((op_w % word_w) == 0);
  endfunction

endpackage

// File: rtl/mp_word_shifter.sv
// Shift-in deserialiser: each enabled word enters at the MSB end and the
// register shifts right, so the first word lands in the LSB slot.
module mp_word_shifter #(
  parameter int unsigned OPERAND_WIDTH = 512,
  parameter int unsigned WORD_WIDTH    = 32
) (
  input  logic                     iClk,
  input  logic                     iClr,
  input  logic                     iEn,
  input  logic [WORD_WIDTH-1:0]    iWord,
  output logic [OPERAND_WIDTH-1:0] oData
);

  logic [OPERAND_WIDTH-1:0] r_data;

  generate
    if (OPERAND_WIDTH == WORD_WIDTH) begin : g_single
      always_ff @(posedge iClk) begin
        if (iClr)     r_data <= '0;
        else if (iEn) r_data <= iWord;
      end
    end else begin : g_multi
      always_ff @(posedge iClk) begin
        if (iClr)     r_data <= '0;
        else if (iEn) r_data <= {iWord, r_data[OPERAND_WIDTH-1:WORD_WIDTH]};
      end
    end
  endgenerate

  assign oData = r_data;

endmodule

// File: rtl/mp_operand_loader.sv
// Operand loader for mp_adder: assembles A then B from a word stream, pulses
// oStart, then holds the operands until iDone or the watchdog expires.
module mp_operand_loader
  import mp_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = 512,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [WORD_WIDTH-1:0]    iWord,
  input  logic                     iValid,
  output logic                     oReady,
  output logic [OPERAND_WIDTH-1:0] oOpA,
  output logic [OPERAND_WIDTH-1:0] oOpB,
  output logic                     oStart,
  input  logic                     iDone,
  output logic                     oBusy,
  output logic                     oTimeout
);

  localparam int unsigned N_WORDS = n_words(OPERAND_WIDTH, WORD_WIDTH);
  localparam int unsigned CNT_W   = cnt_width(N_WORDS);
  localparam int unsigned WD_W    = wd_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  generate
    if (!widths_ok(OPERAND_WIDTH, WORD_WIDTH)) begin : g_width_check
      $error("mp_operand_loader: OPERAND_WIDTH must be a non-zero multiple of WORD_WIDTH");
    end
  endgenerate

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic             r_start;
  logic             r_busy;
  logic             r_timeout;

  logic w_load;
  logic w_accept;
  logic w_last_word;
  logic w_en_a;
  logic w_en_b;

  // Ready is a pure decode of the state register, independent of iValid.
  assign w_load      = (r_state == s_LOAD_A) || (r_state == s_LOAD_B);
  assign w_accept    = iValid && w_load;
  assign w_last_word = (r_cnt == CNT_LAST);
  assign w_en_a      = w_accept && (r_state == s_LOAD_A);
  assign w_en_b      = w_accept && (r_state == s_LOAD_B);

  mp_word_shifter #(
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .WORD_WIDTH    (WORD_WIDTH)
  ) u_shift_a (
    .iClk  (iClk),
    .iClr  (iRst),
    .iEn   (w_en_a),
    .iWord (iWord),
    .oData (oOpA)
  );

  mp_word_shifter #(
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .WORD_WIDTH    (WORD_WIDTH)
  ) u_shift_b (
    .iClk  (iClk),
    .iClr  (iRst),
    .iEn   (w_en_b),
    .iWord (iWord),
    .oData (oOpB)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= s_LOAD_A;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        s_LOAD_A: begin
          if (w_accept) begin
            if (w_last_word) begin
              r_cnt   <= '0;
              r_state <= s_LOAD_B;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        s_LOAD_B: begin
          if (w_accept) begin
            if (w_last_word) begin
              r_cnt   <= '0;
              r_state <= s_START;
              r_start <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        s_START: begin
          r_state <= s_WAIT;
          r_wd    <= '0;
        end
        s_WAIT: begin
          // A completion in the same cycle as expiry takes priority over the watchdog.
          if (iDone) begin
            r_state <= s_LOAD_A;
            r_busy  <= 1'b0;
            r_wd    <= '0;
          end else if ((TIMEOUT_CYC != 0) && (r_wd == WD_LAST)) begin
            r_state   <= s_LOAD_A;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_wd      <= '0;
          end else if (TIMEOUT_CYC != 0) begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: r_state <= s_LOAD_A;
      endcase
    end
  end

  assign oReady   = w_load;
  assign oStart   = r_start;
  assign oBusy    = r_busy;
  assign oTimeout = r_timeout;

endmodule

// File: tb/tb_mp_operand_loader.sv
// Randomised scoreboard bench for mp_operand_loader (64-bit operands, 16-bit words).
module tb_mp_operand_loader;

  localparam int unsigned OW = 64;
  localparam int unsigned WW = 16;
  localparam int unsigned NW = OW / WW;
  localparam int unsigned TO = 8;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [WW-1:0] iWord;
  logic          iValid;
  logic          oReady;
  logic [OW-1:0] oOpA;
  logic [OW-1:0] oOpB;
  logic          oStart;
  logic          oBusy;
  logic          oTimeout;
  logic          done_b = 1'b0;
  logic          done_m = 1'b0;
  wire           iDone = done_b | done_m;

  always #5 iClk = ~iClk;

  mp_operand_loader #(
    .OPERAND_WIDTH (OW),
    .WORD_WIDTH    (WW),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iWord    (iWord),
    .iValid   (iValid),
    .oReady   (oReady),
    .oOpA     (oOpA),
    .oOpB     (oOpB),
    .oStart   (oStart),
    .iDone    (iDone),
    .oBusy    (oBusy),
    .oTimeout (oTimeout)
  );

  typedef struct {
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    int            dly;
    bit            dstart;
    bit            nodone;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp     = 0;
  int            n_bad     = 0;
  bit            b_busy    = 1'b0;
  bit            exp_to    = 1'b0;
  int            total_acc = 0;
  int            exp_acc   = 0;
  logic [WW-1:0] wa[NW];
  logic [WW-1:0] wb[NW];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word i of the stream occupies bits [i*WW +: WW].
  function automatic logic [OW-1:0] assemble(input logic [WW-1:0] w[NW]);
    logic [OW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NW); i++) v = v + (OW'(w[i]) << (i * WW));
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_word(input logic [WW-1:0] w);
    bit r;
    int guard;
    iValid = 1'b1;
    iWord  = w;
    guard  = 0;
    do begin
      @(negedge iClk);
      r = oReady;
      @(posedge iClk);
      #1;
      guard++;
    end while (!r && guard < 200);
    if (!r) chk("send_ready", OW'(r), OW'(1));
  endtask

  task automatic run_txn(input int gapmax, input int dly, input bit dstart, input bit nodone);
    exp_t e;
    int   g;
    e.a = assemble(wa);
    e.b = assemble(wb);
    e.dly = dly;
    e.dstart = dstart;
    e.nodone = nodone;
    exp_q.push_back(e);
    exp_acc += 2 * NW;
    for (int i = 0; i < int'(2 * NW); i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      if (g > 0) begin
        iValid = 1'b0;
        repeat (g) begin @(posedge iClk); #1; end
      end
      send_word((i < int'(NW)) ? wa[i] : wb[i - NW]);
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < int'(NW); i++) begin
      wa[i] = WW'($urandom);
      wb[i] = WW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    iValid = 1'b0;
    while ((exp_q.size() != 0 || b_busy) && g < 400) begin
      @(negedge iClk);
      g++;
    end
    chk("idle_wait", OW'(exp_q.size() != 0 || b_busy), OW'(0));
    @(posedge iClk);
    #1;
  endtask

  // Start-pulse latency and accept counting.
  initial begin
    int  acc;
    bit  exp_start;
    acc = 0;
    exp_start = 1'b0;
    forever begin
      @(negedge iClk);
      if (iRst) begin
        acc = 0;
        exp_start = 1'b0;
      end else begin
        if (oStart || exp_start) chk("start_pulse", OW'(oStart), OW'(exp_start));
        exp_start = 1'b0;
        if (iValid && oReady) begin
          acc++;
          total_acc++;
          if (acc == int'(2 * NW)) begin
            exp_start = 1'b1;
            acc = 0;
          end
        end
      end
    end
  end

  // Scoreboard and mp_adder stand-in: compares operands on oStart, then answers with iDone.
  initial begin
    exp_t          e;
    logic [OW-1:0] ha;
    logic [OW-1:0] hb;
    forever begin
      @(negedge iClk);
      if (oStart === 1'b1 && !iRst) begin
        b_busy = 1'b1;
        if (exp_q.size() == 0) begin
          chk("start_queue", OW'(exp_q.size()), OW'(1));
        end else begin
          e = exp_q.pop_front();
          chk("opA", oOpA, e.a);
          chk("opB", oOpB, e.b);
          chk("start_ready", OW'(oReady), OW'(0));
          chk("start_busy", OW'(oBusy), OW'(1));
          ha = oOpA;
          hb = oOpB;
          if (!e.nodone) begin
            done_b = e.dstart;
            for (int k = 1; k <= e.dly; k++) begin
              @(negedge iClk);
              chk("hold_A", oOpA, ha);
              chk("hold_B", oOpB, hb);
              chk("wait_ready", OW'(oReady), OW'(0));
              chk("wait_busy", OW'(oBusy), OW'(1));
              done_b = (k == e.dly);
            end
            @(negedge iClk);
            done_b = 1'b0;
            chk("post_ready", OW'(oReady), OW'(1));
            chk("post_busy", OW'(oBusy), OW'(0));
            chk("post_timeout", OW'(oTimeout), OW'(exp_to));
          end
        end
        b_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int g;
    int d;
    bit s;
    iRst = 1'b1;
    iValid = 1'b0;
    iWord = '0;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    chk("rst_ready", OW'(oReady), OW'(1));
    chk("rst_start", OW'(oStart), OW'(0));
    chk("rst_busy", OW'(oBusy), OW'(0));
    chk("rst_timeout", OW'(oTimeout), OW'(0));
    chk("rst_opA", oOpA, OW'(0));
    chk("rst_opB", oOpB, OW'(0));
    @(posedge iClk);
    #1;

    // Basic directed transaction
    wa[0] = 16'h1111; wa[1] = 16'h2222; wa[2] = 16'h3333; wa[3] = 16'h4444;
    wb[0] = 16'h000A; wb[1] = 16'h000B; wb[2] = 16'h000C; wb[3] = 16'h000D;
    run_txn(0, 3, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with iValid held high throughout
    for (int t = 0; t < 4; t++) begin
      rand_words();
      d = int'($urandom_range(8, 1));
      s = 1'($urandom_range(1, 0));
      run_txn(0, d, s, 1'b0);
    end
    wait_idle();

    // Same words without and with random gaps
    rand_words();
    run_txn(0, 2, 1'b0, 1'b0);
    wait_idle();
    run_txn(3, 2, 1'b0, 1'b0);
    wait_idle();

    // iDone on the last watchdog cycle, and iDone during the start cycle
    rand_words();
    run_txn(1, 8, 1'b1, 1'b0);
    wait_idle();
    rand_words();
    run_txn(0, 1, 1'b1, 1'b0);
    wait_idle();

    // Watchdog expiry
    rand_words();
    run_txn(0, 0, 1'b0, 1'b1);
    iValid = 1'b0;
    g = 0;
    do begin @(negedge iClk); g++; end while (!oStart && g < 50);
    chk("wd_start_seen", OW'(oStart), OW'(1));
    for (int k = 1; k <= int'(TO); k++) @(negedge iClk);
    chk("wd_before_timeout", OW'(oTimeout), OW'(0));
    chk("wd_before_busy", OW'(oBusy), OW'(1));
    @(negedge iClk);
    chk("wd_timeout", OW'(oTimeout), OW'(1));
    chk("wd_ready", OW'(oReady), OW'(1));
    chk("wd_busy", OW'(oBusy), OW'(0));
    exp_to = 1'b1;
    @(posedge iClk); #1 done_m = 1'b1;
    @(posedge iClk); #1 done_m = 1'b0;
    @(negedge iClk);
    chk("late_done_timeout", OW'(oTimeout), OW'(1));
    chk("late_done_ready", OW'(oReady), OW'(1));
    chk("late_done_busy", OW'(oBusy), OW'(0));
    @(posedge iClk);
    #1;
    rand_words();
    run_txn(1, 3, 1'b0, 1'b0);
    wait_idle();

    // Reset after three A words
    send_word(16'hDEAD);
    send_word(16'hBEEF);
    send_word(16'hCAFE);
    exp_acc += 3;
    iValid = 1'b0;
    iRst = 1'b1;
    @(posedge iClk);
    #1 iRst = 1'b0;
    exp_to = 1'b0;
    @(negedge iClk);
    chk("mid_rst_ready", OW'(oReady), OW'(1));
    chk("mid_rst_start", OW'(oStart), OW'(0));
    chk("mid_rst_busy", OW'(oBusy), OW'(0));
    chk("mid_rst_timeout", OW'(oTimeout), OW'(0));
    chk("mid_rst_opA", oOpA, OW'(0));
    chk("mid_rst_opB", oOpB, OW'(0));
    @(posedge iClk);
    #1;
    rand_words();
    run_txn(0, 4, 1'b0, 1'b0);
    wait_idle();

    chk("accept_count", OW'(total_acc), OW'(exp_acc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
